md_unit: RTL and testbench

// - Execute-stage multiply/divide responder for the controller's start/busy handshake; owns HI and LO.
// - Accepts an op on start, holds busy for a fixed latency and then commits the result to HI/LO.
// - Serves mthi/mtlo writes.
// - The controller stalls the issuing and dependent instructions (mfhi/mflo/md ops) while start|busy.

---
 rtl/md_unit_if.sv | 23 ++
 rtl/md_unit.sv | 142 ++++++++++++++
 tb/tb_md_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Multiply/divide unit port bundle: the controller is the master, md_unit the slave.
interface md_unit_if;
  logic        start;
  logic [2:0]  mdctr;
  logic [31:0] a;
  logic [31:0] b;
  logic        hiwrite;
  logic        lowrite;
  logic [31:0] wd;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, mdctr, a, b, hiwrite, lowrite, wd,
    input  busy, hi, lo
  );

  modport slave (
    input  start, mdctr, a, b, hiwrite, lowrite, wd,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning HI/LO.
// An op is accepted on start while idle. Its result is computed at the start edge
// and held as a pending value. It commits to HI/LO after a fixed busy latency.
// Optional feature macro: MD_MADD_EN enables the MADD/MADDU/MSUB/MSUBU ops (mdctr 4..7).
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        rst,
  md_unit_if.slave   md
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t MultLoad = cnt_t'(MULT_CYCLES);
  localparam cnt_t DivLoad  = cnt_t'(DIV_CYCLES);

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMadd  = 3'd4,
    OpMaddu = 3'd5,
    OpMsub  = 3'd6,
    OpMsubu = 3'd7
  } op_e;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q;
  cnt_t        cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] phi_q, plo_q;

  op_e         op;
  logic        op_valid;
  cnt_t        load;
  logic [63:0] result;

  logic [63:0] a_sx, b_sx, prod_s, prod_u, hilo;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, dvd, dvs, uq, ur, quo, rem;

  assign op      = op_e'(md.mdctr);
  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

  // Result datapath: products, divide and the optional accumulate ops, all evaluated on start.
  always_comb begin
    hilo   = {hi_q, lo_q};
    a_sx   = {{32{md.a[31]}}, md.a};
    b_sx   = {{32{md.b[31]}}, md.b};
    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, md.a} * {32'd0, md.b};

    div_signed = (op == OpDiv);
    a_neg      = div_signed & md.a[31];
    b_neg      = div_signed & md.b[31];
    a_mag      = a_neg ? (32'd0 - md.a) : md.a;
    b_mag      = b_neg ? (32'd0 - md.b) : md.b;
    dvd        = a_mag;
    // Divisor forced to 1 on b==0 to keep the divider defined; that result is discarded.
    dvs        = (md.b == 32'd0) ? 32'd1 : b_mag;
    uq         = dvd / dvs;
    ur         = dvd % dvs;
    // Truncating signed divide: quotient negative on sign mismatch, remainder follows dividend.
    quo        = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    rem        = a_neg ? (32'd0 - ur) : ur;

    op_valid = 1'b1;
    load     = MultLoad;
    result   = hilo;
    case (op)
      OpMult:  result = prod_s;
      OpMultu: result = prod_u;
      OpDiv, OpDivu: begin
        load = DivLoad;
        // Divide by zero re-commits the current HI/LO, i.e. leaves them unchanged.
        if (md.b != 32'd0) result = {rem, quo};
      end
`ifdef MD_MADD_EN
      OpMadd:  result = hilo + prod_s;
      OpMaddu: result = hilo + prod_u;
      OpMsub:  result = hilo - prod_s;
      OpMsubu: result = hilo - prod_u;
`else
      OpMadd, OpMaddu, OpMsub, OpMsubu: op_valid = 1'b0;
`endif
      default: op_valid = 1'b0;
    endcase
  end

  // Control FSM with registered busy, latency counter, pending result and HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (md.start) begin
            // A start, valid or not, blocks mthi/mtlo in the same cycle.
            if (op_valid) begin
              state_q <= StRun;
              busy_q  <= 1'b1;
              cnt_q   <= load;
              phi_q   <= result[63:32];
              plo_q   <= result[31:0];
            end
          end else begin
            if (md.hiwrite) hi_q <= md.wd;
            if (md.lowrite) lo_q <= md.wd;
          end
        end
        StRun: begin
          cnt_q <= cnt_q - cnt_t'(1);
          if (cnt_q == cnt_t'(1)) begin
            hi_q    <= phi_q;
            lo_q    <= plo_q;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit; expectations are hand-computed constants.
// Covers both builds: MD_MADD_EN selects the accumulate expectations.
module tb_md_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;

  md_unit_if mif ();

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .md (mif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles after the current start, bounded at 50.
  task automatic wait_idle(output int n);
    n = 0;
    while (mif.busy === 1'b1 && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] ra, input logic [31:0] rb,
                        output int n);
    mif.start = 1'b1;
    mif.mdctr = op;
    mif.a     = ra;
    mif.b     = rb;
    mif.wd    = ra;
    tick();
    mif.start = 1'b0;
    wait_idle(n);
  endtask

  task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
    mif.hiwrite = hw;
    mif.lowrite = lw;
    mif.wd      = d;
    tick();
    mif.hiwrite = 1'b0;
    mif.lowrite = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    mif.start   = 1'b0;
    mif.mdctr   = 3'd0;
    mif.a       = '0;
    mif.b       = '0;
    mif.hiwrite = 1'b0;
    mif.lowrite = 1'b0;
    mif.wd      = '0;
    #12;
    check("reset_busy", {31'd0, mif.busy}, 32'd0);
    check("reset_hi", mif.hi, 32'd0);
    check("reset_lo", mif.lo, 32'd0);
    rst = 1'b1;
    tick();

    // MULT -3 * 5
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, cyc);
    check("mult_cycles", cyc, 32'd5);
    check("mult_hi", mif.hi, 32'hFFFF_FFFF);
    check("mult_lo", mif.lo, 32'hFFFF_FFF1);

    // MULT min * min = 2^62
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, cyc);
    check("mult_min_hi", mif.hi, 32'h4000_0000);
    check("mult_min_lo", mif.lo, 32'h0);

    // DIVU 100 / 7
    run_op(3'd3, 32'd100, 32'd7, cyc);
    check("divu_cycles", cyc, 32'd10);
    check("divu_lo", mif.lo, 32'd14);
    check("divu_hi", mif.hi, 32'd2);

    // DIV -7 / 2
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
    check("div_neg_lo", mif.lo, 32'hFFFF_FFFD);
    check("div_neg_hi", mif.hi, 32'hFFFF_FFFF);

    // DIV overflow case
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check("div_ovf_lo", mif.lo, 32'h8000_0000);
    check("div_ovf_hi", mif.hi, 32'h0);

    // mthi / mtlo then DIV by zero
    mt(1'b1, 1'b0, 32'h1234);
    mt(1'b0, 1'b1, 32'h5678);
    check("mthi", mif.hi, 32'h1234);
    check("mtlo", mif.lo, 32'h5678);
    run_op(3'd2, 32'd9, 32'd0, cyc);
    check("div0_cycles", cyc, 32'd10);
    check("div0_hi", mif.hi, 32'h1234);
    check("div0_lo", mif.lo, 32'h5678);

    // Both strobes together
    mt(1'b1, 1'b1, 32'hCAFE);
    check("mthilo_hi", mif.hi, 32'hCAFE);
    check("mthilo_lo", mif.lo, 32'hCAFE);

    // Start and hiwrite together: start wins
    mif.hiwrite = 1'b1;
    run_op(3'd1, 32'd3, 32'd4, cyc);
    mif.hiwrite = 1'b0;
    check("start_wins_hi", mif.hi, 32'h0);
    check("start_wins_lo", mif.lo, 32'd12);

    // MULTU in flight: DIVU start and hiwrite at busy cycle 2 are ignored
    mif.start = 1'b1;
    mif.mdctr = 3'd1;
    mif.a     = 32'hFFFF_FFFF;
    mif.b     = 32'd2;
    tick();
    mif.start = 1'b0;
    tick();
    mif.start   = 1'b1;
    mif.mdctr   = 3'd3;
    mif.a       = 32'd100;
    mif.b       = 32'd7;
    mif.hiwrite = 1'b1;
    mif.wd      = 32'hAA;
    tick();
    mif.start   = 1'b0;
    mif.hiwrite = 1'b0;
    wait_idle(cyc);
    check("inflight_cycles", cyc + 2, 32'd5);
    check("inflight_hi", mif.hi, 32'h1);
    check("inflight_lo", mif.lo, 32'hFFFF_FFFE);
    tick();
    check("no_queue_busy", {31'd0, mif.busy}, 32'd0);

    // Reset mid-op at busy cycle 3 of DIVU
    mif.start = 1'b1;
    mif.mdctr = 3'd3;
    mif.a     = 32'd100;
    mif.b     = 32'd7;
    tick();
    mif.start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, mif.busy}, 32'd0);
    check("rst_mid_hi", mif.hi, 32'h0);
    check("rst_mid_lo", mif.lo, 32'h0);
    tick();
    rst = 1'b1;
    repeat (12) tick();
    check("rst_nocommit_hi", mif.hi, 32'h0);
    check("rst_nocommit_lo", mif.lo, 32'h0);
    check("rst_nocommit_busy", {31'd0, mif.busy}, 32'd0);

    // Accumulate ops
    mt(1'b1, 1'b0, 32'h0);
    mt(1'b0, 1'b1, 32'hFFFF_FFFF);
    mif.start = 1'b1;
    mif.mdctr = 3'd5;
    mif.a     = 32'd1;
    mif.b     = 32'd1;
    tick();
    mif.start = 1'b0;
`ifdef MD_MADD_EN
    check("maddu_busy", {31'd0, mif.busy}, 32'd1);
    wait_idle(cyc);
    check("maddu_cycles", cyc, 32'd5);
    check("maddu_hi", mif.hi, 32'h1);
    check("maddu_lo", mif.lo, 32'h0);
    run_op(3'd6, 32'd2, 32'd3, cyc);
    check("msub_hi", mif.hi, 32'h0);
    check("msub_lo", mif.lo, 32'hFFFF_FFFA);
`else
    check("maddu_off_busy", {31'd0, mif.busy}, 32'd0);
    tick();
    check("maddu_off_hi", mif.hi, 32'h0);
    check("maddu_off_lo", mif.lo, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
